// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared constants, FSM state type and paddle helper for the
//                pong LED-matrix scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    localparam int COLS     = 64;
    localparam int ROWS     = 32;
    localparam int PADDLE_H = 4;

    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    // First column of each score field (MSB first, four columns wide)
    localparam int L_SCORE_COL = 2;
    localparam int R_SCORE_COL = 58;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SNAP    = 3'd1,
        SHIFT   = 3'd2,
        LATCH   = 3'd3,
        DISPLAY = 3'd4
    } state_t;

    // Paddle coverage evaluated 7 bits wide so a top value near 63 cannot
    // wrap around into the low rows; rows beyond the panel simply never match.
    function automatic logic paddle_covers(input logic [5:0]       top,
                                           input logic [ROW_W-1:0] row);
        logic [6:0] w_top;
        logic [6:0] w_row;
        w_top = 7'(top);
        w_row = 7'(row);
        return (w_row >= w_top) && (w_row <= w_top + 7'(PADDLE_H - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_matrix_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : pong_matrix_scanner_if
//  Description : Game-state inputs and HUB75-style panel outputs of the
//                scanner. master = game core / panel side, slave = scanner.
//  Ports       : enable, ball_x/y, left/right_paddle_y, left/right_score (in)
//                row_addr, pix_data, pix_clk, pix_latch, pix_oe_n,
//                frame_done (out)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pong_matrix_scanner_if;
    logic       enable;
    logic [5:0] ball_x;
    logic [4:0] ball_y;
    logic [5:0] left_paddle_y;
    logic [5:0] right_paddle_y;
    logic [3:0] left_score;
    logic [3:0] right_score;

    logic [4:0] row_addr;
    logic       pix_data;
    logic       pix_clk;
    logic       pix_latch;
    logic       pix_oe_n;
    logic       frame_done;

    modport master (
        output enable, ball_x, ball_y, left_paddle_y, right_paddle_y,
               left_score, right_score,
        input  row_addr, pix_data, pix_clk, pix_latch, pix_oe_n, frame_done
    );

    modport slave (
        input  enable, ball_x, ball_y, left_paddle_y, right_paddle_y,
               left_score, right_score,
        output row_addr, pix_data, pix_clk, pix_latch, pix_oe_n, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/pong_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pixel_gen
//  Description : Combinational pixel(row, col) from the frame snapshot:
//                paddles, ball, dashed centre net and both scores.
//  Ports       : i_row, i_col       - pixel being shifted
//                i_ball_x/y, i_lpy, i_rpy, i_lscore, i_rscore - snapshot
//                o_pixel            - lit / dark
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_pixel_gen
    import pong_pkg::*;
(
    input  logic [ROW_W-1:0] i_row,
    input  logic [COL_W-1:0] i_col,
    input  logic [5:0]       i_ball_x,
    input  logic [4:0]       i_ball_y,
    input  logic [5:0]       i_lpy,
    input  logic [5:0]       i_rpy,
    input  logic [3:0]       i_lscore,
    input  logic [3:0]       i_rscore,
    output logic             o_pixel
);
    logic       w_left_pad, w_right_pad, w_ball, w_net;
    logic       w_left_score, w_right_score;
    logic [1:0] w_loff, w_roff;

    assign w_left_pad  = (i_col == '0) && paddle_covers(i_lpy, i_row);
    assign w_right_pad = (i_col == COL_W'(COLS - 1)) && paddle_covers(i_rpy, i_row);
    assign w_ball      = (i_col == i_ball_x) && (i_row == i_ball_y);
    assign w_net       = (i_col == COL_W'(COLS / 2 - 1)) && !i_row[0];

    // Offset within a 4-column score field; offset 0 carries the MSB.
    assign w_loff = 2'(i_col - COL_W'(L_SCORE_COL));
    assign w_roff = 2'(i_col - COL_W'(R_SCORE_COL));

    assign w_left_score  = (i_row == '0)
                         && (i_col >= COL_W'(L_SCORE_COL))
                         && (i_col <= COL_W'(L_SCORE_COL + 3))
                         && i_lscore[2'd3 - w_loff];
    assign w_right_score = (i_row == '0)
                         && (i_col >= COL_W'(R_SCORE_COL))
                         && (i_col <= COL_W'(R_SCORE_COL + 3))
                         && i_rscore[2'd3 - w_roff];

    assign o_pixel = w_left_pad | w_right_pad | w_ball | w_net
                   | w_left_score | w_right_score;
endmodule
`default_nettype wire

// File: rtl/pong_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : pong_matrix_scanner
//  Description : Scans a per-frame snapshot of the pong game state onto a
//                64x32 serial-shift LED matrix, one row per scan slot.
//  Ports       : clk, reset (async, active-high)
//                scan_if (slave) - game inputs and panel outputs
//  Parameters  : DWELL - clocks a latched row stays lit (>= 1)
//  Revision    : 1.0 - initial release
// ============================================================================
module pong_matrix_scanner
    import pong_pkg::*;
#(
    parameter int DWELL = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    pong_matrix_scanner_if.slave  scan_if
);
    localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t           r_state, w_next_state;
    logic [ROW_W-1:0] r_row, r_row_addr;
    logic [COL_W-1:0] r_col;
    logic             r_phase;   // 0 = data set-up half, 1 = shift-clock high half
    logic [DW_W-1:0]  r_dwell;

    logic [5:0]       r_bx, r_lpy, r_rpy;
    logic [4:0]       r_by;
    logic [3:0]       r_ls, r_rs;

    logic w_pixel, w_last_col, w_last_row, w_last_dwell;
    logic w_pix_data, w_pix_clk, w_pix_latch, w_pix_oe_n, w_frame_done;

    pong_pixel_gen u_pixel_gen (
        .i_row    (r_row),
        .i_col    (r_col),
        .i_ball_x (r_bx),
        .i_ball_y (r_by),
        .i_lpy    (r_lpy),
        .i_rpy    (r_rpy),
        .i_lscore (r_ls),
        .i_rscore (r_rs),
        .o_pixel  (w_pixel)
    );

    assign w_last_col   = (r_col == COL_W'(COLS - 1)) && r_phase;
    assign w_last_row   = (r_row == ROW_W'(ROWS - 1));
    assign w_last_dwell = (r_dwell == DW_W'(DWELL - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pix_data   = 1'b0;
        w_pix_clk    = 1'b0;
        w_pix_latch  = 1'b0;
        w_pix_oe_n   = 1'b1;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE:  if (scan_if.enable) w_next_state = SNAP;
            SNAP:  w_next_state = SHIFT;
            SHIFT: begin
                w_pix_data = w_pixel;
                w_pix_clk  = r_phase;
                if (w_last_col) w_next_state = LATCH;
            end
            LATCH: begin
                w_pix_latch  = 1'b1;
                w_next_state = DISPLAY;
            end
            DISPLAY: begin
                w_pix_oe_n = 1'b0;
                if (w_last_dwell) begin
                    if (w_last_row) begin
                        w_frame_done = 1'b1;
                        // enable is only consulted at frame boundaries
                        w_next_state = scan_if.enable ? SNAP : IDLE;
                    end else begin
                        w_next_state = SHIFT;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row      <= '0;
            r_col      <= '0;
            r_phase    <= 1'b0;
            r_dwell    <= '0;
            r_row_addr <= '0;
            r_bx       <= '0;
            r_by       <= '0;
            r_lpy      <= '0;
            r_rpy      <= '0;
            r_ls       <= '0;
            r_rs       <= '0;
        end else begin
            case (r_state)
                SNAP: begin
                    // Freeze the game state so the core can update without tearing
                    r_bx    <= scan_if.ball_x;
                    r_by    <= scan_if.ball_y;
                    r_lpy   <= scan_if.left_paddle_y;
                    r_rpy   <= scan_if.right_paddle_y;
                    r_ls    <= scan_if.left_score;
                    r_rs    <= scan_if.right_score;
                    r_row   <= '0;
                    r_col   <= '0;
                    r_phase <= 1'b0;
                    r_dwell <= '0;
                end
                SHIFT: begin
                    r_phase <= ~r_phase;
                    if (r_phase) r_col <= r_col + 1'b1;
                end
                LATCH: begin
                    r_row_addr <= r_row;
                    r_dwell    <= '0;
                end
                DISPLAY: begin
                    r_dwell <= r_dwell + 1'b1;
                    if (w_last_dwell) begin
                        r_row   <= r_row + 1'b1;
                        r_col   <= '0;
                        r_phase <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign scan_if.row_addr   = r_row_addr;
    assign scan_if.pix_data   = w_pix_data;
    assign scan_if.pix_clk    = w_pix_clk;
    assign scan_if.pix_latch  = w_pix_latch;
    assign scan_if.pix_oe_n   = w_pix_oe_n;
    assign scan_if.frame_done = w_frame_done;
endmodule
`default_nettype wire

// File: tb/tb_pong_matrix_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pong_matrix_scanner
//  Description : Self-checking bench for pong_matrix_scanner (DWELL=4).
//                A frame-position model predicts every output each cycle;
//                literal row images and timing totals pin the model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pong_matrix_scanner;
    import pong_pkg::*;

    localparam int DWELL = 4;
    localparam int LROW  = 2 * COLS + 1 + DWELL;   // cycles per row slot
    localparam int FRAME = 1 + ROWS * LROW;        // 4257

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pong_matrix_scanner_if bus ();

    pong_matrix_scanner #(.DWELL(DWELL)) dut (
        .clk     (clk),
        .reset   (reset),
        .scan_if (bus)
    );

    int ck_total = 0;
    int ck_pass  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        ck_total++;
        if (act === exp) ck_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endfunction

    // ---------------- behavioural model -----------------
    bit         m_run = 1'b0;
    int         m_t   = 0;      // cycle index inside the frame, 0 = SNAP
    int         m_row_addr = 0;
    int         m_bx, m_by, m_lpy, m_rpy;
    logic [3:0] m_ls, m_rs;

    function automatic bit ref_pixel(int r, int c);
        bit p = 1'b0;
        if (c == 0 && r >= m_lpy && r < m_lpy + PADDLE_H)        p = 1'b1;
        if (c == COLS - 1 && r >= m_rpy && r < m_rpy + PADDLE_H) p = 1'b1;
        if (c == m_bx && r == m_by)                              p = 1'b1;
        if (c == COLS / 2 - 1 && (r % 2) == 0)                   p = 1'b1;
        if (r == 0 && c >= 2 && c <= 5 && ((m_ls >> (5 - c)) & 4'd1) != 0)    p = 1'b1;
        if (r == 0 && c >= 58 && c <= 61 && ((m_rs >> (61 - c)) & 4'd1) != 0) p = 1'b1;
        return p;
    endfunction

    always @(negedge clk) begin
        logic       e_data, e_clk, e_lat, e_oe, e_fd;
        int         e_row, k, row, o;
        logic [9:0] act, exp;
        e_data = 1'b0; e_clk = 1'b0; e_lat = 1'b0; e_oe = 1'b1; e_fd = 1'b0;
        row = 0; o = 0;
        if (reset) begin
            m_run = 1'b0; m_t = 0; m_row_addr = 0;
        end else if (m_run) begin
            if (m_t == 0) begin
                m_bx = int'(bus.ball_x);  m_by = int'(bus.ball_y);
                m_lpy = int'(bus.left_paddle_y); m_rpy = int'(bus.right_paddle_y);
                m_ls = bus.left_score; m_rs = bus.right_score;
            end else begin
                k = m_t - 1; row = k / LROW; o = k % LROW;
                if (o < 2 * COLS) begin
                    e_clk  = (o % 2) == 1;
                    e_data = ref_pixel(row, o / 2);
                end else if (o == 2 * COLS) begin
                    e_lat = 1'b1;
                end else begin
                    e_oe = 1'b0;
                    e_fd = (row == ROWS - 1) && (o == LROW - 1);
                end
            end
        end
        e_row = m_row_addr;
        act = {bus.row_addr, bus.pix_data, bus.pix_clk, bus.pix_latch, bus.pix_oe_n, bus.frame_done};
        exp = {e_row[4:0], e_data, e_clk, e_lat, e_oe, e_fd};
        chk($sformatf("outputs_t%0d", m_t), 64'(act), 64'(exp));
        if (!reset) begin
            if (e_lat) m_row_addr = row;
            if (m_run) begin
                if (m_t == FRAME - 1) begin
                    m_t = 0;
                    if (!bus.enable) m_run = 1'b0;
                end else begin
                    m_t++;
                end
            end else if (bus.enable) begin
                m_run = 1'b1; m_t = 0;
            end
        end
    end

    // ---------------- row capture and per-frame totals -----------------
    logic [63:0] cap [ROWS];
    logic [63:0] sh;
    bit          pend;
    int cnt_clk, cnt_lat, cnt_oe, cnt_len;
    int f_clk, f_lat, f_oe, f_len;

    always @(negedge clk) begin
        if (reset) begin
            sh = '0; pend = 1'b0;
            cnt_clk = 0; cnt_lat = 0; cnt_oe = 0; cnt_len = 0;
        end else begin
            if (pend) begin cap[bus.row_addr] = sh; pend = 1'b0; end
            if (bus.pix_clk)   sh = {bus.pix_data, sh[63:1]};   // column 0 ends at bit 0
            if (bus.pix_latch) pend = 1'b1;
            cnt_clk += int'(bus.pix_clk);
            cnt_lat += int'(bus.pix_latch);
            cnt_oe  += int'(!bus.pix_oe_n);
            cnt_len++;
            if (bus.frame_done) begin
                f_clk = cnt_clk; f_lat = cnt_lat; f_oe = cnt_oe; f_len = cnt_len;
                cnt_clk = 0; cnt_lat = 0; cnt_oe = 0; cnt_len = 0;
            end
        end
    end

    // ---------------- stimulus -----------------
    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic set_game(int bx, int by, int lpy, int rpy, logic [3:0] ls, logic [3:0] rs);
        bus.ball_x = 6'(bx); bus.ball_y = 5'(by);
        bus.left_paddle_y = 6'(lpy); bus.right_paddle_y = 6'(rpy);
        bus.left_score = ls; bus.right_score = rs;
    endtask

    task automatic wait_fd(string name);
        int n = 0;
        bit seen = 1'b0;
        while (n < FRAME + 50 && !seen) begin
            @(negedge clk); n++;
            if (bus.frame_done === 1'b1) seen = 1'b1;
        end
        if (!seen) chk(name, 64'(seen), 64'd1);
        tick();
    endtask

    task automatic wait_row(int r);
        int n = 0;
        while (n < FRAME + 50 && int'(bus.row_addr) != r) begin @(negedge clk); n++; end
        if (int'(bus.row_addr) != r) chk("wait_row_timeout", 64'(bus.row_addr), 64'(r));
    endtask

    initial begin
        int n, fd_cnt;
        logic [63:0] col0;
        bus.enable = 1'b1;
        set_game(10, 5, 12, 20, 4'd0, 4'd0);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_row_addr",   64'(bus.row_addr),   64'd0);
        chk("reset_pix_data",   64'(bus.pix_data),   64'd0);
        chk("reset_pix_clk",    64'(bus.pix_clk),    64'd0);
        chk("reset_pix_latch",  64'(bus.pix_latch),  64'd0);
        chk("reset_pix_oe_n",   64'(bus.pix_oe_n),   64'd1);
        chk("reset_frame_done", 64'(bus.frame_done), 64'd0);
        tick(); reset = 1'b0;

        // IDLE, SNAP, SHIFT even, SHIFT odd -> clock high on the 4th negedge
        n = 0;
        do begin @(negedge clk); n++; end while (bus.pix_clk !== 1'b1 && n < 20);
        chk("first_pix_clk_negedge", 64'(n), 64'd4);

        // Frame 1: ball (10,5), paddles 12/20, scores 0
        wait_fd("frame1_timeout");
        set_game(40, 3, 30, 0, 4'b1010, 4'b0001);   // snapped for frame 2
        chk("f1_row0",  cap[0],  64'h0000_0000_8000_0000);
        chk("f1_row5",  cap[5],  64'h0000_0000_0000_0400);
        chk("f1_row12", cap[12], 64'h0000_0000_8000_0001);
        chk("f1_row20", cap[20], 64'h8000_0000_8000_0000);
        chk("f1_pix_clk_rises", 64'(f_clk), 64'(64 * 32));
        chk("f1_latches",       64'(f_lat), 64'd32);
        chk("f1_oe_low_cycles", 64'(f_oe),  64'(4 * 32));

        // Frame 2: clip at bottom, right paddle at top, scores
        wait_fd("frame2_timeout");
        set_game(5, 9, 63, 40, 4'd0, 4'd0);         // snapped for frame 3
        chk("frame_length", 64'(f_len), 64'd4257);
        chk("f2_row0_scores", cap[0],  64'hA000_0000_8000_0014);
        chk("f2_row3",        cap[3],  64'h8000_0100_0000_0000);
        chk("f2_row30_clip",  cap[30], 64'h0000_0000_8000_0001);
        chk("f2_row31_clip",  cap[31], 64'h0000_0000_0000_0001);

        // Frame 3: paddles entirely off-panel
        wait_fd("frame3_timeout");
        set_game(10, 5, 12, 20, 4'd0, 4'd0);        // snapped for frame 4
        col0 = '0;
        for (int r = 0; r < ROWS; r++) col0[r] = cap[r][0];
        chk("f3_col0_never_lit", col0, 64'd0);
        chk("f3_row9_ball", cap[9], 64'h0000_0000_0000_0020);
        chk("f3_frame_length", 64'(f_len), 64'd4257);

        // Frame 4: inputs change mid-frame (row 20 not yet shifted)
        repeat (2000) tick();
        set_game(50, 20, 0, 0, 4'hF, 4'hF);
        wait_fd("frame4_timeout");
        chk("f4_row5",  cap[5],  64'h0000_0000_0000_0400);
        chk("f4_row12", cap[12], 64'h0000_0000_8000_0001);
        chk("f4_row20_untorn", cap[20], 64'h8000_0000_8000_0000);

        // Frame 5: drop enable at row 7
        wait_row(7);
        tick(); bus.enable = 1'b0;
        fd_cnt = 0;
        for (int i = 0; i < FRAME + 200; i++) begin
            @(negedge clk);
            fd_cnt += int'(bus.frame_done);
        end
        chk("disable_frame_done_count", 64'(fd_cnt), 64'd1);
        chk("idle_pix_oe_n", 64'(bus.pix_oe_n), 64'd1);
        chk("idle_pix_clk",  64'(bus.pix_clk),  64'd0);

        // Reset pulse in the middle of a shift-clock high phase
        tick(); bus.enable = 1'b1;
        wait_row(3);
        n = 0;
        do begin @(negedge clk); n++; end while (bus.pix_clk !== 1'b1 && n < 400);
        chk("pre_reset_pix_clk_high", 64'(bus.pix_clk), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk("midreset_pix_clk",  64'(bus.pix_clk),   64'd0);
        chk("midreset_row_addr", 64'(bus.row_addr),  64'd0);
        chk("midreset_pix_oe_n", 64'(bus.pix_oe_n),  64'd1);
        chk("midreset_latch",    64'(bus.pix_latch), 64'd0);
        chk("midreset_pix_data", 64'(bus.pix_data),  64'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (300) tick();

        $display("%0d/%0d checks passed", ck_pass, ck_total);
        $finish;
    end
endmodule
`default_nettype wire
